rlc_tick_service: RTL and testbench
===================================

// Module: rlc_tick_service
// PURPOSE
//   Hardware service engine for the 16-bit-register Avalon interval timer
//   (50 MHz sys clock). Acts as the timer's sole bus master: programs the
//   period, starts the timer in continuous mode with IRQ enabled, and clears
//   each timeout. Converts every timeout into a game tick (valid/ready
//   handshake) and a divided slow tick. Sits between the sys-clk timer and
//   the game logic, so the CPU never services the timer IRQ.
// PARAMETERS
//   PERIOD_DEFAULT  32'd49999  period loaded after reset (1 ms at 50 MHz)
//   TICK_DIV        16'd50     serviced ticks per slow_tick pulse (>=1)
// PORTS
//   clk             in   1   system clock
//   reset_n         in   1   asynchronous active-low reset
//   cfg_period      in   32  new timer period (count-1 form)
//   cfg_load        in   1   1-cycle strobe: reprogram timer with cfg_period
//   cfg_busy        out  1   combinational: state!=IDLE || tmr_irq
//   tick_valid      out  1   game tick pending
//   tick_ready      in   1   consumer accepts tick
//   slow_tick       out  1   1-cycle pulse every TICK_DIV serviced ticks
//   tick_count      out  32  serviced timeouts since reset, wraps
//   overrun_count   out  8   ticks lost while tick_valid unaccepted, saturates
//   timer_err       out  1   sticky: timer not running after programming
//   tmr_address     out  3   timer register address
//   tmr_chipselect  out  1   timer select
//   tmr_write_n     out  1   timer write, active low
//   tmr_writedata   out  16  timer write data
//   tmr_readdata    in   16  timer read data, 1-cycle registered latency
//   tmr_irq         in   1   timer interrupt, level
// BEHAVIOUR
// - One clock; async active-low reset. All outputs registered except cfg_busy.
//   Reset values: chipselect=0, write_n=1, address=0, writedata=0, all tick,
//   count, err outputs 0; state=PROG_STOP; period latch=PERIOD_DEFAULT.
// - Bus: 1 access per cycle, no waitrequest. Writes take effect at the edge
//   ending the access cycle. For a read, address is driven in RD_ADDR and
//   tmr_readdata is sampled in the following RD_DATA cycle.
// - FSM, one cycle per state unless noted:
//   PROG_STOP  wr addr1 = 0x0008 (stop)
//   PROG_PL    wr addr2 = period[15:0]
//   PROG_PH    wr addr3 = period[31:16]
//   PROG_CTRL  wr addr1 = 0x0007 (start|cont|ito). Must directly follow
//              PROG_PH, so start beats the force-reload stop in the same cycle.
//   RD_ADDR    rd addr0
//   RD_DATA    sample; bit1 (running)==0 -> timer_err<=1 (sticky)
//   IDLE       tmr_irq=1 -> ACK; else cfg_load=1 -> latch cfg_period, go to
//              PROG_STOP. Otherwise stay. chipselect=0.
//   ACK        wr addr0 = 0x0000 (clear TO); service the tick (below)
//   ACK_GUARD  no access (irq deasserts); -> IDLE
// - Tick service, on the ACK cycle edge:
//   - tick_count+1 (wraps 2^32).
//   - If tick_valid && !tick_ready: overrun_count+1, saturating at 255;
//     tick_valid stays 1. Otherwise tick_valid<=1.
//   - Divider increments; at TICK_DIV-1 it wraps to 0 and slow_tick=1 for
//     one cycle.
// - tick_valid clears on tick_valid && tick_ready, unless ACK sets it in the
//   same cycle (set wins).
// - cfg_load is accepted only when cfg_busy=0; otherwise it is ignored and
//   the caller retries. If irq and cfg_load both occur in IDLE, the irq is
//   serviced and cfg_load is dropped.
// - cfg_period=0 is clamped to 1.
// - Reprogramming does not reset tick_count, overrun_count or the divider.
// - Reset mid-sequence aborts any access (bus idle at once). The full PROG
//   sequence reruns with PERIOD_DEFAULT.
// TESTING
// 1 Reset release -> writes a1=0008, a2=C34F, a3=0000, a1=0007 on consecutive
//   cycles, then read a0; timer model returns 0x0002 -> timer_err=0, IDLE.
// 2 Pulse tmr_irq in IDLE, tick_ready=1 -> a0 write of 0x0000 within 1 cycle;
//   tick_count=1, tick_valid high 1 cycle.
// 3 TICK_DIV=50, 100 irqs -> slow_tick exactly 2 pulses, after irqs 50 and 100.
// 4 tick_ready=0, 300 irqs -> overrun_count=255 (saturated), tick_valid=1;
//   then tick_ready=1 -> tick_valid=0 next cycle.
// 5 cfg_load with cfg_period=0x0001_86A0 in IDLE -> a1=0008, a2=86A0,
//   a3=0001, a1=0007; cfg_load while cfg_busy=1 -> no bus activity.
// 6 Timer model holds running=0 -> timer_err=1 after RD_DATA; reset mid-PROG_PH
//   -> bus idle immediately, sequence restarts at PROG_STOP.

Source files
------------

// File: rtl/rlc_tick_service.sv
// Bus-master service engine for an Avalon interval timer: programs the period,
// acknowledges every timeout and turns it into a game tick plus a divided slow tick.
module rlc_tick_service #(
  parameter logic [31:0] PERIOD_DEFAULT = 32'd49999,
  parameter logic [15:0] TICK_DIV       = 16'd50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cfg_load,
  output logic        cfg_busy,
  output logic        tick_valid,
  input  logic        tick_ready,
  output logic        slow_tick,
  output logic [31:0] tick_count,
  output logic [7:0]  overrun_count,
  output logic        timer_err,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  typedef enum logic [3:0] {
    S_PROG_STOP = 4'd0,
    S_PROG_PL   = 4'd1,
    S_PROG_PH   = 4'd2,
    S_PROG_CTRL = 4'd3,
    S_RD_ADDR   = 4'd4,
    S_RD_DATA   = 4'd5,
    S_IDLE      = 4'd6,
    S_ACK       = 4'd7,
    S_ACK_GUARD = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [2:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [15:0] wd_q, wd_d;
  logic        valid_q, valid_d;
  logic        slow_q, slow_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        err_q, err_d;
  logic [15:0] div_q, div_d;
  logic        rd_unused_s;

  assign rd_unused_s = ^{tmr_readdata[15:2], tmr_readdata[0]};

  // Next-state logic; PROG_STOP holds until its write is actually on the bus,
  // which only matters for the first cycle after reset where the bus is idle.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    case (state_q)
      S_PROG_STOP: begin
        if (cs_q) state_d = S_PROG_PL;
        else      state_d = S_PROG_STOP;
      end
      S_PROG_PL:   state_d = S_PROG_PH;
      S_PROG_PH:   state_d = S_PROG_CTRL;
      S_PROG_CTRL: state_d = S_RD_ADDR;
      S_RD_ADDR:   state_d = S_RD_DATA;
      S_RD_DATA:   state_d = S_IDLE;
      S_IDLE: begin
        if (tmr_irq) begin
          state_d = S_ACK;
        end else if (cfg_load) begin
          state_d  = S_PROG_STOP;
          period_d = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK:       state_d = S_ACK_GUARD;
      S_ACK_GUARD: state_d = S_IDLE;
      default:     state_d = S_PROG_STOP;
    endcase
  end

  // Bus decode of the upcoming state, so the registered bus lines up with state_q.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    case (state_d)
      S_PROG_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008; end
      S_PROG_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_q[15:0]; end
      S_PROG_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_q[31:16]; end
      S_PROG_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0007; end
      S_RD_ADDR:   begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd0; wd_d = 16'h0000; end
      S_ACK:       begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wd_d = 16'h0000; end
      default:     begin cs_d = 1'b0; wn_d = 1'b1; addr_d = 3'd0; wd_d = 16'h0000; end
    endcase
  end

  // Tick service on the ACK edge; a new tick outranks a same-cycle consumer accept.
  always_comb begin
    count_d = count_q;
    ovr_d   = ovr_q;
    div_d   = div_q;
    slow_d  = 1'b0;
    if (valid_q && tick_ready) valid_d = 1'b0;
    else                       valid_d = valid_q;
    if (state_q == S_ACK) begin
      count_d = count_q + 32'd1;
      if (valid_q && !tick_ready) begin
        if (ovr_q != 8'd255) ovr_d = ovr_q + 8'd1;
        else                 ovr_d = ovr_q;
      end else begin
        valid_d = 1'b1;
      end
      if (div_q == (TICK_DIV - 16'd1)) begin
        div_d  = 16'd0;
        slow_d = 1'b1;
      end else begin
        div_d = div_q + 16'd1;
      end
    end else begin
      count_d = count_q;
    end
    if (state_q == S_RD_DATA && !tmr_readdata[1]) err_d = 1'b1;
    else                                          err_d = err_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_PROG_STOP;
      period_q <= PERIOD_DEFAULT;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= 3'd0;
      wd_q     <= 16'h0000;
      valid_q  <= 1'b0;
      slow_q   <= 1'b0;
      count_q  <= 32'd0;
      ovr_q    <= 8'd0;
      err_q    <= 1'b0;
      div_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      valid_q  <= valid_d;
      slow_q   <= slow_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
      div_q    <= div_d;
    end
  end

  assign cfg_busy       = (state_q != S_IDLE) || tmr_irq;
  assign tick_valid     = valid_q;
  assign slow_tick      = slow_q;
  assign tick_count     = count_q;
  assign overrun_count  = ovr_q;
  assign timer_err      = err_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = wd_q;

endmodule

// File: tb/tb_rlc_tick_service.sv
// Scoreboard bench for rlc_tick_service with a small behavioural interval-timer model.
module tb_rlc_tick_service;

  localparam logic [31:0] PDEF = 32'd49999;
  localparam int          TDIV = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_load = 1'b0;
  logic        cfg_busy;
  logic        tick_valid;
  logic        tick_ready = 1'b1;
  logic        slow_tick;
  logic [31:0] tick_count;
  logic [7:0]  overrun_count;
  logic        timer_err;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  rlc_tick_service #(.PERIOD_DEFAULT(PDEF), .TICK_DIV(16'd50)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_load(cfg_load),
    .cfg_busy(cfg_busy), .tick_valid(tick_valid), .tick_ready(tick_ready),
    .slow_tick(slow_tick), .tick_count(tick_count), .overrun_count(overrun_count),
    .timer_err(timer_err), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #10 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Timer model: TO flag, running bit, registered status read.
  logic        irq_req = 1'b0;
  logic        stuck = 1'b0;
  logic        to_q, run_q;
  logic [15:0] rd_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= 1'b0; run_q <= 1'b0; rd_q <= 16'h0000;
    end else begin
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) to_q <= 1'b0;
      else if (irq_req) to_q <= 1'b1;
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1) begin
        if (tmr_writedata[3]) run_q <= 1'b0;
        else if (tmr_writedata[2]) run_q <= 1'b1;
      end
      rd_q <= (tmr_chipselect && tmr_write_n && tmr_address == 3'd0) ?
              {14'd0, run_q & ~stuck, to_q} : 16'h0000;
    end
  end
  assign tmr_irq = to_q;
  assign tmr_readdata = rd_q;

  logic [31:0] bus_q[$];
  logic [31:0] slow_q[$];
  logic [31:0] mon_exp;
  int exp_ticks, exp_div, exp_ovr;
  bit exp_valid;

  function automatic logic [31:0] acc(input logic [2:0] a, input logic wn, input logic [15:0] d);
    return {12'd0, a, wn, d};
  endfunction

  // Bus and slow-tick monitors pop the scoreboard whenever the DUT produces output.
  always @(negedge clk) begin
    if (reset_n && tmr_chipselect) begin
      if (bus_q.size() == 0) check_val("bus_unexpected", 32'(bus_q.size()), 32'd1);
      else begin
        mon_exp = bus_q.pop_front();
        check_val("bus", acc(tmr_address, tmr_write_n, tmr_writedata), mon_exp);
      end
    end
    if (reset_n && slow_tick) begin
      if (slow_q.size() == 0) check_val("slow_unexpected", 32'(slow_q.size()), 32'd1);
      else begin
        mon_exp = slow_q.pop_front();
        check_val("slow_at", tick_count, mon_exp);
      end
    end
  end

  task automatic push_prog(input logic [31:0] p);
    bus_q.push_back(acc(3'd1, 1'b0, 16'h0008));
    bus_q.push_back(acc(3'd2, 1'b0, p[15:0]));
    bus_q.push_back(acc(3'd3, 1'b0, p[31:16]));
    bus_q.push_back(acc(3'd1, 1'b0, 16'h0007));
    bus_q.push_back(acc(3'd0, 1'b1, 16'h0000));
  endtask

  task automatic model_reset();
    bus_q.delete(); slow_q.delete();
    exp_ticks = 0; exp_div = 0; exp_ovr = 0; exp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (cfg_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'd0, cfg_busy}, 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_bus", {27'd0, tmr_chipselect, tmr_write_n, tmr_address}, {27'd0, 1'b0, 1'b1, 3'd0});
    check_val("rst_wdata", {16'd0, tmr_writedata}, 32'd0);
    check_val("rst_flags", {20'd0, tick_valid, slow_tick, timer_err, 1'b0, overrun_count}, 32'd0);
    check_val("rst_count", tick_count, 32'd0);
    push_prog(PDEF);
    reset_n = 1'b1;
    wait_idle("idle_after_reset");
  endtask

  task automatic model_irq();
    bus_q.push_back(acc(3'd0, 1'b0, 16'h0000));
    exp_ticks++;
    exp_div++;
    if (exp_div == TDIV) begin
      exp_div = 0;
      slow_q.push_back(32'(exp_ticks));
    end
    if (exp_valid && !tick_ready) begin
      if (exp_ovr < 255) exp_ovr++;
    end else exp_valid = 1'b1;
    if (tick_ready) exp_valid = 1'b0;
  endtask

  task automatic fire_irq();
    model_irq();
    @(posedge clk); #1 irq_req = 1'b1;
    @(posedge clk); #1 irq_req = 1'b0;
    wait_idle("idle_after_irq");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset programming sequence and clean status read.
    reset_dut();
    check_val("err_clean", {31'd0, timer_err}, 32'd0);

    // Single irq: ACK write latency and a one-cycle tick.
    tick_ready = 1'b1;
    model_irq();
    @(posedge clk); #1 irq_req = 1'b1;
    @(posedge clk); #1 irq_req = 1'b0;
    n = 0;
    while (!tmr_chipselect && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("ack_latency", 32'(n), 32'd2);
    check_val("valid_in_ack", {31'd0, tick_valid}, 32'd0);
    @(negedge clk);
    check_val("valid_set", {31'd0, tick_valid}, 32'd1);
    check_val("count_1", tick_count, 32'd1);
    @(negedge clk);
    check_val("valid_cleared", {31'd0, tick_valid}, 32'd0);
    wait_idle("idle_t2");

    // Slow tick after irqs 50 and 100 from a fresh reset.
    reset_dut();
    for (int i = 0; i < 100; i++) fire_irq();
    check_val("slow_pending", 32'(slow_q.size()), 32'd0);
    check_val("count_100", tick_count, 32'd100);

    // Overrun saturation with the consumer stalled.
    tick_ready = 1'b0;
    for (int i = 0; i < 300; i++) fire_irq();
    check_val("ovr_model", {24'd0, overrun_count}, 32'(exp_ovr));
    check_val("ovr_sat", {24'd0, overrun_count}, 32'd255);
    check_val("valid_held", {31'd0, tick_valid}, 32'd1);
    @(posedge clk); #1 tick_ready = 1'b1;
    @(negedge clk);
    check_val("valid_before_accept", {31'd0, tick_valid}, 32'd1);
    @(negedge clk);
    check_val("valid_after_accept", {31'd0, tick_valid}, 32'd0);
    exp_valid = 1'b0;

    // Reprogramming; a second load while busy must be ignored.
    push_prog(32'h0001_86A0);
    @(posedge clk); #1 cfg_period = 32'h0001_86A0; cfg_load = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0;
    @(posedge clk); #1 cfg_period = 32'h0000_0005; cfg_load = 1'b1;
    check_val("busy_during_prog", {31'd0, cfg_busy}, 32'd1);
    @(posedge clk); #1 cfg_load = 1'b0;
    wait_idle("idle_after_cfg");
    check_val("count_kept", tick_count, 32'(exp_ticks));
    check_val("ovr_kept", {24'd0, overrun_count}, 32'(exp_ovr));
    push_prog(32'd1);
    @(posedge clk); #1 cfg_period = 32'd0; cfg_load = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0;
    wait_idle("idle_after_clamp");
    fire_irq();
    check_val("count_after_cfg", tick_count, 32'(exp_ticks));

    // Timer that never runs sets the sticky error.
    stuck = 1'b1;
    reset_dut();
    check_val("err_set", {31'd0, timer_err}, 32'd1);
    repeat (3) @(negedge clk);
    check_val("err_sticky", {31'd0, timer_err}, 32'd1);
    stuck = 1'b0;

    // Reset while PROG_PH is on the bus.
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    push_prog(PDEF);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!(tmr_chipselect && tmr_address == 3'd3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("reach_ph", {29'd0, tmr_address}, 32'd3);
    reset_n = 1'b0;
    #1;
    check_val("abort_idle", {31'd0, tmr_chipselect}, 32'd0);
    model_reset();
    push_prog(PDEF);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle("idle_after_abort");
    check_val("err_after_abort", {31'd0, timer_err}, 32'd0);

    repeat (5) @(negedge clk);
    check_val("bus_pending", 32'(bus_q.size()), 32'd0);
    check_val("slow_left", 32'(slow_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
